riscv_axi_rd_mux: RTL and testbench
===================================

RISCV_AXI_RD_MUX -- requirements
Module: riscv_axi_rd_mux

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, meaning the number of upstream AXI read masters (legal range 2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the read data width.
REQ-004 The block SHALL have parameter ID_W, default 4, meaning the upstream ID width.
REQ-005 The block SHALL have parameter MAX_OUT, default 4, meaning the outstanding-burst limit per port (legal range 1..15).
REQ-006 The block SHALL use IDX_W = max(1, clog2(NUM_PORTS)) and CNT_W = clog2(MAX_OUT+1).
REQ-007 The block SHALL have port ACLK, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port ARESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have upstream AR inputs s_arvalid [NUM_PORTS], s_araddr [NUM_PORTS*ADDR_W], s_arid [NUM_PORTS*ID_W] and s_arlen [NUM_PORTS*8].
REQ-010 The block SHALL have upstream AR output s_arready [NUM_PORTS].
REQ-011 The block SHALL have upstream R outputs s_rvalid [NUM_PORTS], and s_rdata [DATA_W], s_rid [ID_W], s_rresp [2] and s_rlast [1], the last four broadcast to all ports.
REQ-012 The block SHALL have upstream R input s_rready [NUM_PORTS].
REQ-013 The block SHALL have downstream AR outputs m_arvalid [1], m_araddr [ADDR_W], m_arid [IDX_W+ID_W] and m_arlen [8].
REQ-014 The block SHALL have downstream AR input m_arready [1].
REQ-015 The block SHALL have downstream R inputs m_rvalid [1], m_rdata [DATA_W], m_rid [IDX_W+ID_W], m_rresp [2] and m_rlast [1], and R output m_rready [1].
REQ-016 The block SHALL have output outstanding [NUM_PORTS*CNT_W]: the per-port in-flight burst count.
REQ-017 The block SHALL have output err_unmapped [1]: a sticky flag for R beats with an illegal or unexpected index.

Function
REQ-018 AR path SHALL be a two-state FSM with states IDLE and HOLD.
REQ-019 A port SHALL be eligible when s_arvalid=1 and its count < MAX_OUT.
REQ-020 In IDLE, the block SHALL combinationally select the first eligible port searching from rr_ptr upward, modulo NUM_PORTS.
REQ-021 In IDLE, the block SHALL assert s_arready only for the selected port; all other s_arready SHALL be 0.
REQ-022 On an upstream handshake, the block SHALL register {port index, s_arid}, s_araddr and s_arlen into the m_ar* outputs, set rr_ptr = (selected+1) mod NUM_PORTS, and go to HOLD.
REQ-023 In HOLD, the block SHALL hold m_arvalid=1 with all m_ar* fields stable, and all s_arready=0.
REQ-024 When m_arready=1 in HOLD, the block SHALL return to IDLE.
REQ-025 AR latency SHALL be: m_arvalid rises the cycle after the upstream handshake; throughput is at most one burst per 2 cycles.
REQ-026 The per-port count SHALL increment on that port's upstream AR handshake.
REQ-027 The per-port count SHALL decrement on an R handshake (m_rvalid & m_rready) with m_rlast=1 routed to that port.
REQ-028 A simultaneous increment and decrement on the same port SHALL leave its count unchanged.
REQ-029 The R path SHALL be combinational with zero latency.
REQ-030 The R path SHALL route using p = m_rid[IDX_W+ID_W-1:ID_W], setting s_rvalid[p] = m_rvalid (others 0) and m_rready = s_rready[p].
REQ-031 The block SHALL drive s_rid = m_rid[ID_W-1:0] and pass s_rdata, s_rresp and s_rlast through unchanged.
REQ-032 If p >= NUM_PORTS, or count[p] == 0, during m_rvalid, the block SHALL force m_rready=1, assert no s_rvalid, leave counts unchanged, and set err_unmapped=1 from the next edge.
REQ-033 err_unmapped SHALL be cleared only by reset.
REQ-034 A port at count == MAX_OUT SHALL be skipped by arbitration with no effect on rr_ptr.

Reset
REQ-035 While ARESETn=0, asynchronously: state=IDLE, m_arvalid=0, m_araddr/m_arid/m_arlen=0, rr_ptr=0, all counts=0, err_unmapped=0.
REQ-036 Reset asserted mid-burst SHALL discard all in-flight tracking; no recovery of lost R beats is required.
REQ-037 The first arbitration after reset deassertion SHALL start from port 0.

Verification
REQ-038 Scenario round-robin: with NUM_PORTS=2 and both s_arvalid=1 continuously, m_arready=1 -> grants alternate 0,1,0,1 and m_arid[4] alternates 0,1.
REQ-039 Scenario routing: m_rid=0x13 (p=1, id=3), m_rlast=1, s_rready[1]=1 -> s_rvalid=2'b10, s_rid=3, outstanding[1] decrements by 1.
REQ-040 Scenario limit: with MAX_OUT=4, port 0 issues 4 bursts with no R response -> 5th request is stalled (s_arready[0]=0), port 1 is still granted; one RLAST to port 0 -> port 0 is granted again.
REQ-041 Scenario HOLD backpressure: m_arready=0 for 5 cycles after a grant -> m_ar* stable for all 5 cycles, s_arready=0 throughout; m_arready=1 -> IDLE on the next cycle.
REQ-042 Scenario unmapped: NUM_PORTS=3, m_rid index=3, m_rvalid=1 -> m_rready=1, s_rvalid=0, err_unmapped=1 and it stays 1 until ARESETn=0.
REQ-043 Scenario reset: ARESETn driven low while in HOLD with outstanding[0]=2 -> immediately m_arvalid=0 and outstanding=0, without waiting for an ACLK edge.

Source files
------------

// File: rtl/riscv_axi_rd_mux.sv
// N:1 AXI read-channel multiplexer: round-robin AR arbitration with per-port
// outstanding-burst limits, and zero-latency R routing by the ID prefix.
module riscv_axi_rd_mux #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ID_W      = 4,
   parameter int unsigned MAX_OUT   = 4,
   localparam int unsigned IDX_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
   localparam int unsigned CNT_W    = $clog2(MAX_OUT + 1)
) (
   input  logic                        ACLK,
   input  logic                        ARESETn,
   // upstream AR
   input  logic [NUM_PORTS-1:0]        s_arvalid,
   input  logic [NUM_PORTS*ADDR_W-1:0] s_araddr,
   input  logic [NUM_PORTS*ID_W-1:0]   s_arid,
   input  logic [NUM_PORTS*8-1:0]      s_arlen,
   output logic [NUM_PORTS-1:0]        s_arready,
   // upstream R
   output logic [NUM_PORTS-1:0]        s_rvalid,
   output logic [DATA_W-1:0]           s_rdata,
   output logic [ID_W-1:0]             s_rid,
   output logic [1:0]                  s_rresp,
   output logic                        s_rlast,
   input  logic [NUM_PORTS-1:0]        s_rready,
   // downstream AR
   output logic                        m_arvalid,
   output logic [ADDR_W-1:0]           m_araddr,
   output logic [IDX_W+ID_W-1:0]       m_arid,
   output logic [7:0]                  m_arlen,
   input  logic                        m_arready,
   // downstream R
   input  logic                        m_rvalid,
   input  logic [DATA_W-1:0]           m_rdata,
   input  logic [IDX_W+ID_W-1:0]       m_rid,
   input  logic [1:0]                  m_rresp,
   input  logic                        m_rlast,
   output logic                        m_rready,
   // status
   output logic [NUM_PORTS*CNT_W-1:0]  outstanding,
   output logic                        err_unmapped
);

   localparam int unsigned MID_W = IDX_W + ID_W;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]          r_state;
   logic [0:0]          w_state_nxt;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [CNT_W-1:0]    r_cnt [NUM_PORTS];
   logic [ADDR_W-1:0]   r_araddr;
   logic [MID_W-1:0]    r_arid;
   logic [7:0]          r_arlen;
   logic                r_err;

   logic [NUM_PORTS-1:0]   w_elig;
   logic [2*NUM_PORTS-1:0] w_rot;
   logic                   w_found;
   logic [IDX_W-1:0]       w_sel;
   logic [IDX_W:0]         w_sum;
   logic                   w_ar_hs;
   logic [ADDR_W-1:0]      w_sel_addr;
   logic [ID_W-1:0]        w_sel_id;
   logic [7:0]             w_sel_len;

   logic [IDX_W-1:0]       w_rport;
   logic                   w_rlegal;
   logic                   w_rcnt_zero;
   logic                   w_rready_sel;
   logic                   w_rbad;
   logic                   w_rlast_hs;

   // Eligibility: request pending and below the outstanding limit
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         w_elig[i] = s_arvalid[i] && (r_cnt[i] < CNT_W'(MAX_OUT));
      end
   end

   // Rotate so bit 0 is the rr_ptr port, then take the first set bit
   assign w_rot = {w_elig, w_elig} >> r_rr_ptr;

   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_sum   = '0;
      for (int j = 0; j < int'(NUM_PORTS); j++) begin
         if (!w_found && w_rot[j]) begin
            w_found = 1'b1;
            w_sum   = {1'b0, r_rr_ptr} + (IDX_W+1)'(j);
            if (w_sum >= (IDX_W+1)'(NUM_PORTS)) begin
               w_sum = w_sum - (IDX_W+1)'(NUM_PORTS);
            end
            w_sel = w_sum[IDX_W-1:0];
         end
      end
   end

   // Selected port's AR payload
   always_comb begin
      w_sel_addr = '0;
      w_sel_id   = '0;
      w_sel_len  = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (w_sel == IDX_W'(i)) begin
            w_sel_addr = s_araddr[i*ADDR_W +: ADDR_W];
            w_sel_id   = s_arid[i*ID_W +: ID_W];
            w_sel_len  = s_arlen[i*8 +: 8];
         end
      end
   end

   // AR FSM state register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // AR FSM next state and upstream ready
   always_comb begin
      w_state_nxt = r_state;
      w_ar_hs     = 1'b0;
      s_arready   = '0;
      case (r_state)
         ST_IDLE: begin
            w_ar_hs = w_found;
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
               s_arready[i] = w_found && (w_sel == IDX_W'(i));
            end
            if (w_found) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (m_arready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Downstream AR payload and round-robin pointer
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_araddr <= '0;
         r_arid   <= '0;
         r_arlen  <= '0;
         r_rr_ptr <= '0;
      end else if (w_ar_hs) begin
         r_araddr <= w_sel_addr;
         r_arid   <= {w_sel, w_sel_id};
         r_arlen  <= w_sel_len;
         r_rr_ptr <= (w_sel == IDX_W'(NUM_PORTS - 1)) ? '0 : w_sel + IDX_W'(1);
      end
   end

   assign m_arvalid = (r_state == ST_HOLD);
   assign m_araddr  = r_araddr;
   assign m_arid    = r_arid;
   assign m_arlen   = r_arlen;

   // R routing: an unknown index or a port with nothing in flight is sunk
   assign w_rport = m_rid[MID_W-1:ID_W];

   always_comb begin
      w_rlegal     = 1'b0;
      w_rcnt_zero  = 1'b1;
      w_rready_sel = 1'b0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (w_rport == IDX_W'(i)) begin
            w_rlegal     = 1'b1;
            w_rcnt_zero  = (r_cnt[i] == '0);
            w_rready_sel = s_rready[i];
         end
      end
   end

   assign w_rbad     = !w_rlegal || w_rcnt_zero;
   assign m_rready   = w_rbad ? 1'b1 : w_rready_sel;
   assign w_rlast_hs = m_rvalid && m_rready && m_rlast && !w_rbad;

   always_comb begin
      s_rvalid = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         s_rvalid[i] = m_rvalid && !w_rbad && (w_rport == IDX_W'(i));
      end
   end

   assign s_rdata = m_rdata;
   assign s_rid   = m_rid[ID_W-1:0];
   assign s_rresp = m_rresp;
   assign s_rlast = m_rlast;

   // Per-port in-flight burst counters
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if ((w_ar_hs && (w_sel == IDX_W'(i))) &&
                !(w_rlast_hs && (w_rport == IDX_W'(i)))) begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else if (!(w_ar_hs && (w_sel == IDX_W'(i))) &&
                         (w_rlast_hs && (w_rport == IDX_W'(i)))) begin
               r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      outstanding = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         outstanding[i*CNT_W +: CNT_W] = r_cnt[i];
      end
   end

   // Sticky error for R beats that could not be routed
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_err <= 1'b0;
      end else if (m_rvalid && w_rbad) begin
         r_err <= 1'b1;
      end
   end

   assign err_unmapped = r_err;

endmodule

// File: tb/tb_riscv_axi_rd_mux.sv
// Directed bench for riscv_axi_rd_mux: a 2-port instance for arbitration,
// limits, routing and reset, plus a 3-port instance for unmapped indices.
module tb_riscv_axi_rd_mux;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [1:0]  s_arvalid = '0;
   logic [63:0] s_araddr = '0;
   logic [7:0]  s_arid = '0;
   logic [15:0] s_arlen = '0;
   logic [1:0]  s_arready;
   logic [1:0]  s_rvalid;
   logic [31:0] s_rdata;
   logic [3:0]  s_rid;
   logic [1:0]  s_rresp;
   logic        s_rlast;
   logic [1:0]  s_rready = '0;
   logic        m_arvalid;
   logic [31:0] m_araddr;
   logic [4:0]  m_arid;
   logic [7:0]  m_arlen;
   logic        m_arready = 1'b0;
   logic        m_rvalid = 1'b0;
   logic [31:0] m_rdata = '0;
   logic [4:0]  m_rid = '0;
   logic [1:0]  m_rresp = '0;
   logic        m_rlast = 1'b0;
   logic        m_rready;
   logic [5:0]  outstanding;
   logic        err_unmapped;

   logic [2:0]  s3_arready, s3_rvalid;
   logic [31:0] s3_rdata;
   logic [3:0]  s3_rid;
   logic [1:0]  s3_rresp;
   logic        s3_rlast;
   logic        m3_arvalid;
   logic [31:0] m3_araddr;
   logic [5:0]  m3_arid;
   logic [7:0]  m3_arlen;
   logic        m3_rvalid = 1'b0;
   logic [5:0]  m3_rid = '0;
   logic        m3_rlast = 1'b0;
   logic        m3_rready;
   logic [8:0]  out3;
   logic        err3;

   int n_chk = 0;
   int n_pass = 0;

   always #5 ACLK = ~ACLK;

   riscv_axi_rd_mux #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .ID_W(4), .MAX_OUT(4)) u_dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
      .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rready(s_rready),
      .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
      .m_arready(m_arready),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp),
      .m_rlast(m_rlast), .m_rready(m_rready),
      .outstanding(outstanding), .err_unmapped(err_unmapped)
   );

   riscv_axi_rd_mux #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .ID_W(4), .MAX_OUT(4)) u_dut3 (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_arvalid(3'b000), .s_araddr(96'h0), .s_arid(12'h0), .s_arlen(24'h0),
      .s_arready(s3_arready),
      .s_rvalid(s3_rvalid), .s_rdata(s3_rdata), .s_rid(s3_rid), .s_rresp(s3_rresp),
      .s_rlast(s3_rlast), .s_rready(3'b000),
      .m_arvalid(m3_arvalid), .m_araddr(m3_araddr), .m_arid(m3_arid), .m_arlen(m3_arlen),
      .m_arready(1'b0),
      .m_rvalid(m3_rvalid), .m_rdata(32'h0), .m_rid(m3_rid), .m_rresp(2'b00),
      .m_rlast(m3_rlast), .m_rready(m3_rready),
      .outstanding(out3), .err_unmapped(err3)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge ACLK);
   endtask

   // One IDLE cycle checking the grant, then one HOLD cycle (m_arready must be 1)
   task automatic ar_grant(input string tag, input logic [1:0] exp_rdy);
      #1 check_val(tag, s_arready, exp_rdy);
      step();
      step();
   endtask

   task automatic r_beat(input logic [4:0] rid, input logic last, input logic [1:0] rdy);
      m_rvalid = 1'b1; m_rid = rid; m_rlast = last; s_rready = rdy;
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;
   endtask

   initial begin
      // reset values
      step(); step();
      #1;
      check_val("rst_arvalid", m_arvalid, 1'b0);
      check_val("rst_arid", m_arid, 5'h00);
      check_val("rst_araddr", m_araddr, 32'h0);
      check_val("rst_outstanding", outstanding, 6'h00);
      check_val("rst_err", err_unmapped, 1'b0);
      step();
      ARESETn = 1'b1;

      // round-robin with both ports requesting
      s_araddr = {32'h0000_2000, 32'h0000_1000};
      s_arid   = {4'h5, 4'h2};
      s_arlen  = {8'd7, 8'd3};
      m_arready = 1'b1;
      s_arvalid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1 check_val("rr_grant", s_arready, (k % 2) ? 2'b10 : 2'b01);
         step();
         #1;
         check_val("rr_arvalid", m_arvalid, 1'b1);
         check_val("rr_arid", m_arid, (k % 2) ? 5'h15 : 5'h02);
         check_val("rr_araddr", m_araddr, (k % 2) ? 32'h2000 : 32'h1000);
         check_val("rr_arlen", m_arlen, (k % 2) ? 8'd7 : 8'd3);
         check_val("rr_hold_rdy", s_arready, 2'b00);
         if (k == 3) s_arvalid = 2'b00;
         step();
      end
      #1 check_val("rr_outstanding", outstanding, 6'b010_010);

      // R routing to port 1
      m_rvalid = 1'b1; m_rid = 5'h13; m_rlast = 1'b1; s_rready = 2'b10;
      m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b10;
      #1;
      check_val("route_rvalid", s_rvalid, 2'b10);
      check_val("route_rid", s_rid, 4'h3);
      check_val("route_rdata", s_rdata, 32'hDEAD_BEEF);
      check_val("route_rresp", s_rresp, 2'b10);
      check_val("route_rlast", s_rlast, 1'b1);
      check_val("route_rready", m_rready, 1'b1);
      step();
      m_rid = 5'h10; s_rready = 2'b01;
      #1;
      check_val("route_dec", outstanding, 6'b001_010);
      check_val("route_stall_rready", m_rready, 1'b0);
      check_val("route_stall_rvalid", s_rvalid, 2'b10);
      step();
      #1 check_val("route_stall_cnt", outstanding, 6'b001_010);

      // simultaneous AR grant and RLAST on port 1
      s_arvalid = 2'b10; s_rready = 2'b10;
      #1;
      check_val("simul_grant", s_arready, 2'b10);
      check_val("simul_rready", m_rready, 1'b1);
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0; s_arvalid = 2'b00;
      #1 check_val("simul_cnt", outstanding, 6'b001_010);
      step();

      // non-last beat leaves the count alone, then drain everything
      r_beat(5'h00, 1'b0, 2'b01);
      #1 check_val("nonlast_cnt", outstanding, 6'b001_010);
      r_beat(5'h00, 1'b1, 2'b01);
      r_beat(5'h00, 1'b1, 2'b01);
      r_beat(5'h10, 1'b1, 2'b10);
      #1;
      check_val("drain_cnt", outstanding, 6'h00);
      check_val("drain_err", err_unmapped, 1'b0);

      // HOLD backpressure
      m_arready = 1'b0; s_arvalid = 2'b01;
      #1 check_val("bp_grant", s_arready, 2'b01);
      step();
      s_araddr[31:0] = 32'hAAAA_0000; s_arid[3:0] = 4'hF; s_arvalid = 2'b11;
      for (int c = 0; c < 5; c++) begin
         #1;
         check_val("bp_arvalid", m_arvalid, 1'b1);
         check_val("bp_araddr", m_araddr, 32'h1000);
         check_val("bp_arid", m_arid, 5'h02);
         check_val("bp_arlen", m_arlen, 8'd3);
         check_val("bp_arready", s_arready, 2'b00);
         step();
      end
      m_arready = 1'b1; s_arvalid = 2'b00;
      s_araddr[31:0] = 32'h0000_1000; s_arid[3:0] = 4'h2;
      step();
      #1 check_val("bp_idle", m_arvalid, 1'b0);

      // outstanding limit on port 0 (count 1, rr_ptr 1)
      s_arvalid = 2'b01;
      ar_grant("lim_fill", 2'b01);
      ar_grant("lim_fill", 2'b01);
      ar_grant("lim_fill", 2'b01);
      #1 check_val("lim_full", outstanding, 6'b000_100);
      s_arvalid = 2'b11;
      ar_grant("lim_p1", 2'b10);
      ar_grant("lim_skip", 2'b10);
      s_arvalid = 2'b00;
      r_beat(5'h00, 1'b1, 2'b11);
      s_arvalid = 2'b11;
      ar_grant("lim_regrant", 2'b01);
      s_arvalid = 2'b00;
      #1 check_val("lim_cnt", outstanding, 6'b010_100);
      for (int b = 0; b < 4; b++) r_beat(5'h00, 1'b1, 2'b11);
      for (int b = 0; b < 2; b++) r_beat(5'h10, 1'b1, 2'b11);
      #1 check_val("lim_drain", outstanding, 6'h00);

      // asynchronous reset while in HOLD with two bursts on port 0
      s_arvalid = 2'b01;
      ar_grant("arst_pre", 2'b01);
      m_arready = 1'b0;
      #1 check_val("arst_grant", s_arready, 2'b01);
      step();
      #1;
      check_val("arst_hold", m_arvalid, 1'b1);
      check_val("arst_cnt", outstanding, 6'b000_010);
      #1 ARESETn = 1'b0;
      #1;
      check_val("arst_arvalid", m_arvalid, 1'b0);
      check_val("arst_outstanding", outstanding, 6'h00);
      check_val("arst_arid", m_arid, 5'h00);
      step();
      ARESETn = 1'b1; m_arready = 1'b1; s_arvalid = 2'b11;
      #1 check_val("arst_first_p0", s_arready, 2'b01);
      step();
      s_arvalid = 2'b00;
      step();

      // R beat to a port with nothing in flight
      m_rvalid = 1'b1; m_rid = 5'h1A; m_rlast = 1'b1; s_rready = 2'b00;
      #1;
      check_val("unexp_rready", m_rready, 1'b1);
      check_val("unexp_rvalid", s_rvalid, 2'b00);
      check_val("unexp_err_pre", err_unmapped, 1'b0);
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      #1;
      check_val("unexp_err", err_unmapped, 1'b1);
      check_val("unexp_cnt", outstanding, 6'b000_001);
      step(); step();
      #1 check_val("err_sticky", err_unmapped, 1'b1);

      // index 3 on a 3-port mux
      m3_rvalid = 1'b1; m3_rid = 6'h30; m3_rlast = 1'b1;
      #1;
      check_val("unmap3_rready", m3_rready, 1'b1);
      check_val("unmap3_rvalid", s3_rvalid, 3'b000);
      check_val("unmap3_err_pre", err3, 1'b0);
      step();
      m3_rvalid = 1'b0; m3_rlast = 1'b0;
      #1 check_val("unmap3_err", err3, 1'b1);
      step();
      #1 check_val("unmap3_sticky", err3, 1'b1);

      // only reset clears the error flags
      ARESETn = 1'b0;
      #1;
      check_val("clr_err", err_unmapped, 1'b0);
      check_val("clr_err3", err3, 1'b0);
      check_val("clr_out3", out3, 9'h000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Absolute time limit so the bench always ends
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
